muldiv_unit: RTL

Iterative RV32M multiply/divide responder that sits beside the ALU in the EX stage.
- EX issues a request with already-forwarded operands.
- The unit raises a busy/stall toward the hazard unit, then returns a one-cycle completion with the result and the destination register for EX/MEM.
- All eight M-extension ops share one shift/add-subtract datapath.

---
 rtl/muldiv_unit_pkg.sv | 47 ++++
 rtl/muldiv_unit_signfix.sv | 34 +++
 rtl/muldiv_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Holds the funct3 op encodings, the FSM state encodings, the iteration
// count and small decode helpers used by the top and the sign-fix block.
package muldiv_unit_pkg;

    localparam int unsigned MD_XLEN = 32;
    localparam int unsigned MD_ITER = 32;

    typedef enum logic [2:0] {
        MD_OP_MUL    = 3'b000,
        MD_OP_MULH   = 3'b001,
        MD_OP_MULHSU = 3'b010,
        MD_OP_MULHU  = 3'b011,
        MD_OP_DIV    = 3'b100,
        MD_OP_DIVU   = 3'b101,
        MD_OP_REM    = 3'b110,
        MD_OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_CALC = 2'd1,
        MD_ST_FIX  = 2'd2,
        MD_ST_DONE = 2'd3
    } md_state_e;

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic md_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic md_rs1_signed(input logic [2:0] op);
        return (op == MD_OP_MUL)    || (op == MD_OP_MULH) ||
               (op == MD_OP_MULHSU) || (op == MD_OP_DIV)  ||
               (op == MD_OP_REM);
    endfunction

    function automatic logic md_rs2_signed(input logic [2:0] op);
        return (op == MD_OP_MUL) || (op == MD_OP_MULH) ||
               (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_signfix.sv
// Combinational sign handling for the multiply/divide unit.
// Input side: per-op sign flags and absolute values of both operands.
// Output side: optional two's-complement negation of a 64-bit value.
// Ports:
//   i_op      funct3 of the operation whose operands are on i_a/i_b
//   i_a, i_b  raw operands
//   o_mag_a/b operand magnitudes (unchanged when treated as unsigned)
//   o_sign_a/b operand sign flags (0 when treated as unsigned)
//   i_neg     negate i_val when set
//   i_val     value to correct; o_val is the corrected value
module muldiv_unit_signfix
    import muldiv_unit_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_mag_a,
    output logic [31:0] o_mag_b,
    output logic        o_sign_a,
    output logic        o_sign_b,
    input  logic        i_neg,
    input  logic [63:0] i_val,
    output logic [63:0] o_val
);

    always_comb begin
        o_sign_a = md_rs1_signed(i_op) & i_a[31];
        o_sign_b = md_rs2_signed(i_op) & i_b[31];
        o_mag_a  = o_sign_a ? (32'd0 - i_a) : i_a;
        o_mag_b  = o_sign_b ? (32'd0 - i_b) : i_b;
        o_val    = i_neg ? (64'd0 - i_val) : i_val;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One shared 33-bit add/subtract datapath runs shift-add multiply or
// restoring divide over 32 iterations on operand magnitudes; a FIX cycle
// applies sign correction and word selection.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start_i          request strobe, sampled only in IDLE
//   op_i             funct3 (MUL..REMU)
//   rs1_data_i/rs2   forwarded operands
//   rd_addr_i        destination register carried with the request
//   flush_i          aborts any operation; next edge returns to IDLE
//   busy_o           stall request while CALC or FIX
//   done_o           one-cycle completion pulse
//   result_o         result, held until the next accepted start
//   rd_addr_o        latched destination, valid with done_o
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FAST_SPECIAL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    md_state_e   r_state;
    md_state_e   w_state_next;
    md_op_e      r_op;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic [31:0] r_opb;      // multiplicand or divisor magnitude
    logic        r_sa;
    logic        r_sb;
    logic        r_divzero;

    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_sign_a;
    logic        w_sign_b;
    logic        w_fix_neg;
    logic [63:0] w_fix_in;
    logic [63:0] w_fix_out;
    logic [31:0] w_fix_res;

    logic        w_accept;
    logic        w_divzero;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_special_res;

    logic [32:0] w_lhs;
    logic [32:0] w_rhs;
    logic        w_cin;
    logic [33:0] w_sum;
    logic [63:0] w_acc_next;

    muldiv_unit_signfix u_signfix (
        .i_op     (op_i),
        .i_a      (rs1_data_i),
        .i_b      (rs2_data_i),
        .o_mag_a  (w_mag_a),
        .o_mag_b  (w_mag_b),
        .o_sign_a (w_sign_a),
        .o_sign_b (w_sign_b),
        .i_neg    (w_fix_neg),
        .i_val    (w_fix_in),
        .o_val    (w_fix_out)
    );

    // Request decode and divide special cases
    always_comb begin
        w_accept  = (r_state == MD_ST_IDLE) && start_i && !flush_i;
        w_divzero = (rs2_data_i == '0);
        w_ovf     = ((op_i == MD_OP_DIV) || (op_i == MD_OP_REM)) &&
                    (rs1_data_i == 32'h8000_0000) && (rs2_data_i == '1);
        w_special = (FAST_SPECIAL != 0) && md_is_div(op_i) && (w_divzero || w_ovf);
        if (w_divzero) begin
            w_special_res = op_i[1] ? rs1_data_i : '1;
        end else begin
            w_special_res = op_i[1] ? '0 : 32'h8000_0000;
        end
    end

    // Shared adder: multiply adds the multiplicand into the high half,
    // divide subtracts the divisor from the shifted-in partial remainder
    // (carry out of bit 33 means no borrow).
    always_comb begin
        if (md_is_div(r_op)) begin
            w_lhs = {r_acc[63:32], r_acc[31]};
            w_rhs = ~{1'b0, r_opb};
            w_cin = 1'b1;
        end else begin
            w_lhs = {1'b0, r_acc[63:32]};
            w_rhs = r_acc[0] ? {1'b0, r_opb} : 33'd0;
            w_cin = 1'b0;
        end
        w_sum = {1'b0, w_lhs} + {1'b0, w_rhs} + {33'd0, w_cin};

        if (md_is_div(r_op)) begin
            if (w_sum[33]) begin
                w_acc_next = {w_sum[31:0], r_acc[30:0], 1'b1};
            end else begin
                w_acc_next = {w_lhs[31:0], r_acc[30:0], 1'b0};
            end
        end else begin
            w_acc_next = {w_sum[32:0], r_acc[31:1]};
        end
    end

    // Sign correction and word select. Divide-by-zero keeps the all-ones
    // quotient unsigned so the iterative path matches the fast path.
    always_comb begin
        w_fix_in  = r_acc;
        w_fix_neg = r_sa ^ r_sb;
        if (md_is_div(r_op)) begin
            if (md_is_rem(r_op)) begin
                w_fix_in  = {32'd0, r_acc[63:32]};
                w_fix_neg = r_sa;
            end else begin
                w_fix_in  = {32'd0, r_acc[31:0]};
                w_fix_neg = (r_sa ^ r_sb) & ~r_divzero;
            end
        end
        w_fix_res = ((r_op == MD_OP_MUL) || md_is_div(r_op)) ? w_fix_out[31:0]
                                                             : w_fix_out[63:32];
    end

    // Next-state and status outputs
    always_comb begin
        w_state_next = r_state;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            MD_ST_IDLE: begin
                if (start_i && !flush_i) begin
                    w_state_next = w_special ? MD_ST_DONE : MD_ST_CALC;
                end
            end
            MD_ST_CALC: begin
                busy_o = 1'b1;
                if (r_cnt == 6'(MD_ITER - 1)) begin
                    w_state_next = MD_ST_FIX;
                end
            end
            MD_ST_FIX: begin
                busy_o       = 1'b1;
                w_state_next = MD_ST_DONE;
            end
            MD_ST_DONE: begin
                done_o       = 1'b1;
                w_state_next = MD_ST_IDLE;
            end
            default: w_state_next = MD_ST_IDLE;
        endcase
        if (flush_i) begin
            w_state_next = MD_ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= MD_ST_IDLE;
            r_op      <= MD_OP_MUL;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_divzero <= 1'b0;
            result_o  <= '0;
            rd_addr_o <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                MD_ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= md_op_e'(op_i);
                        r_cnt     <= '0;
                        r_acc     <= {32'd0, w_mag_a};
                        r_opb     <= w_mag_b;
                        r_sa      <= w_sign_a;
                        r_sb      <= w_sign_b;
                        r_divzero <= w_divzero;
                        rd_addr_o <= rd_addr_i;
                        if (w_special) begin
                            result_o <= w_special_res;
                        end
                    end
                end
                MD_ST_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    r_acc <= w_acc_next;
                end
                MD_ST_FIX: begin
                    if (!flush_i) begin
                        result_o <= w_fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
